note_render_ctrl: RTL and testbench



---
 rtl/note_render_ctrl_pkg.sv | 14 +
 rtl/note_render_ctrl_strobe_delay.sv | 15 +
 rtl/note_render_ctrl.sv | 102 ++++++++++
 tb/tb_note_render_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/note_render_ctrl_pkg.sv
// note_render_ctrl_pkg: shared states and geometry for the note-highway sequencer
package note_render_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_DEFAULT, S_DEF_DRAIN, S_BEAT_WAIT, S_JUDGE, S_ADD, S_SHIFT,
    S_BOX_SETTLE, S_BOX_DRAW, S_BOX_DRAIN, S_DONE
  } state_t;
  localparam int GRID_W = 240;
  localparam int GRID_H = 180;
  localparam int GRID_PIX = GRID_W * GRID_H;
  localparam int BOX_DIM = 60;
  localparam int BOX_PIX = 3600;
  localparam int NUM_BOXES = 12;
  localparam int PIPE_LAT = 3;
endpackage

// File: rtl/note_render_ctrl_strobe_delay.sv
// strobe_delay: N-stage strobe shift register with async clear
module strobe_delay #(
  parameter int N = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [N-1:0] sr;
  always_ff @(posedge clock or posedge reset)
    if (reset) sr <= '0;
    else sr <= {sr[N-2:0], d};
  assign q = sr[N-1];
endmodule

// File: rtl/note_render_ctrl.sv
// note_render_ctrl: sweeps the default playfield, then sequences beats, box redraws and score strobes
module note_render_ctrl
  import note_render_ctrl_pkg::*;
#(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int SONG_BEATS = 115
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] gridCounter,
  output logic [15:0] memAddressGridCounter,
  output logic [3:0]  boxCounter,
  output logic [14:0] pixelCount,
  output logic [14:0] memAddressPixelCount,
  output logic        loadDefault,
  output logic        writeDefault,
  output logic        shiftSong,
  output logic        loadX,
  output logic        loadY,
  output logic        writeToScreen,
  output logic        changeScore,
  output logic        addScore,
  output logic        songDone,
  output logic        plot,
  output logic        busy
);
  state_t state, nextState;
  logic [7:0] gx, gy, bx;
  logic [6:0] by;
  logic [1:0] drainCnt;
  logic [31:0] timer;
  logic [15:0] beatCount;
  logic sweeping, drawing, sweepLast, pixLast, beatDue, songEnd;
  assign sweeping = state == S_DEFAULT;
  assign drawing = state == S_BOX_DRAW;
  assign sweepLast = memAddressGridCounter == 16'(GRID_PIX - 1);
  assign pixLast = memAddressPixelCount == 15'(BOX_PIX - 1);
  assign beatDue = timer >= 32'(BEAT_CYCLES - 3);
  assign songEnd = beatCount + 16'd1 == 16'(SONG_BEATS);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:       nextState = start ? S_DEFAULT : S_IDLE;
      S_DEFAULT:    nextState = sweepLast ? S_DEF_DRAIN : S_DEFAULT;
      S_DEF_DRAIN:  nextState = drainCnt == 2'd1 ? S_BEAT_WAIT : S_DEF_DRAIN;
      S_BEAT_WAIT:  nextState = beatDue ? S_JUDGE : S_BEAT_WAIT;
      S_JUDGE:      nextState = S_ADD;
      S_ADD:        nextState = S_SHIFT;
      S_SHIFT:      nextState = songEnd ? S_DONE : S_BOX_SETTLE;
      S_BOX_SETTLE: nextState = S_BOX_DRAW;
      S_BOX_DRAW:   nextState = pixLast ? S_BOX_DRAIN : S_BOX_DRAW;
      S_BOX_DRAIN:  nextState = drainCnt != 2'd2 ? S_BOX_DRAIN :
                                boxCounter == 4'(NUM_BOXES) ? S_BEAT_WAIT : S_BOX_SETTLE;
      default:      nextState = S_IDLE;
    endcase
  end
  // Sweep coordinate trails the ROM address by one cycle to match ROM read latency
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      memAddressGridCounter <= '0;
      gridCounter <= '0;
      gx <= '0;
      gy <= '0;
      drainCnt <= '0;
      timer <= '0;
      beatCount <= '0;
      boxCounter <= '0;
      memAddressPixelCount <= '0;
      bx <= '0;
      by <= '0;
    end else begin
      memAddressGridCounter <= sweeping && !sweepLast ? memAddressGridCounter + 16'd1 : '0;
      gx <= sweeping && gx != 8'(GRID_W - 1) ? gx + 8'd1 : '0;
      gy <= !sweeping ? '0 : gx == 8'(GRID_W - 1) ? gy + 8'd1 : gy;
      if (sweeping) gridCounter <= {gx, gy};
      drainCnt <= (state == S_DEF_DRAIN || state == S_BOX_DRAIN) && nextState == state ? drainCnt + 2'd1 : '0;
      timer <= state inside {S_IDLE, S_DEFAULT, S_DEF_DRAIN, S_SHIFT, S_DONE} ? '0 : timer + 32'd1;
      beatCount <= sweeping ? '0 : state == S_SHIFT ? beatCount + 16'd1 : beatCount;
      boxCounter <= state == S_SHIFT ? (songEnd ? 4'd0 : 4'd1) :
                    state == S_BOX_DRAIN && nextState == S_BOX_SETTLE ? boxCounter + 4'd1 :
                    state == S_BOX_DRAIN && nextState == S_BEAT_WAIT ? 4'd0 : boxCounter;
      memAddressPixelCount <= drawing && !pixLast ? memAddressPixelCount + 15'd1 : '0;
      by <= drawing && by != 7'(BOX_DIM - 1) ? by + 7'd1 : '0;
      bx <= !drawing ? '0 : by == 7'(BOX_DIM - 1) ? bx + 8'd1 : bx;
    end
  assign pixelCount = {bx, by};
  assign busy = state != S_IDLE;
  assign writeDefault = sweeping || state == S_DEF_DRAIN;
  assign loadDefault = (sweeping && memAddressGridCounter != 16'd0) || state == S_DEF_DRAIN;
  assign changeScore = state == S_JUDGE;
  assign addScore = state == S_ADD;
  assign shiftSong = state == S_SHIFT;
  assign songDone = state == S_DONE;
  assign loadX = drawing;
  assign loadY = drawing;
  strobe_delay #(.N(2)) wtsDelay (.clock(clock), .reset(reset), .d(drawing), .q(writeToScreen));
  strobe_delay #(.N(PIPE_LAT)) plotDelay (.clock(clock), .reset(reset), .d(drawing || sweeping), .q(plot));
endmodule

// File: tb/tb_note_render_ctrl.sv
// tb_note_render_ctrl: scoreboard bench for sweep, beat sequencing, box redraw and song end
module tb_note_render_ctrl;
  localparam int BEAT = 43300;
  localparam int BEATS = 2;
  typedef struct {int kind; int box; int j;} ev_t;
  logic clock = 0, reset = 1, start = 0;
  logic [15:0] gridCounter, memAddressGridCounter;
  logic [3:0] boxCounter;
  logic [14:0] pixelCount, memAddressPixelCount;
  logic loadDefault, writeDefault, shiftSong, loadX, loadY, writeToScreen;
  logic changeScore, addScore, songDone, plot, busy;
  logic [76:0] allOut;
  int total = 0, bad = 0;
  ev_t q[$];
  note_render_ctrl #(.BEAT_CYCLES(BEAT), .SONG_BEATS(BEATS)) dut (
    .clock(clock), .reset(reset), .start(start),
    .gridCounter(gridCounter), .memAddressGridCounter(memAddressGridCounter),
    .boxCounter(boxCounter), .pixelCount(pixelCount), .memAddressPixelCount(memAddressPixelCount),
    .loadDefault(loadDefault), .writeDefault(writeDefault), .shiftSong(shiftSong),
    .loadX(loadX), .loadY(loadY), .writeToScreen(writeToScreen), .changeScore(changeScore),
    .addScore(addScore), .songDone(songDone), .plot(plot), .busy(busy));
  assign allOut = {gridCounter, memAddressGridCounter, boxCounter, pixelCount, memAddressPixelCount,
                   loadDefault, writeDefault, shiftSong, loadX, loadY, writeToScreen,
                   changeScore, addScore, songDone, plot, busy};
  always #5 clock = ~clock;

  task automatic push(input int k, input int b, input int j);
    ev_t e;
    e.kind = k;
    e.box = b;
    e.j = j;
    q.push_back(e);
  endtask

  function automatic int obsKind();
    return changeScore ? 0 : addScore ? 1 : shiftSong ? 2 : plot ? 3 : songDone ? 4 : -1;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if (allOut !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", allOut); end
    reset = 0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    start = 1;
    @(negedge clock);
    start = 0;
    repeat (20) @(negedge clock);
    total++;
    if ({writeDefault, plot} !== 2'b11) begin bad++; $display("FAIL mid_sweep: wd/plot got %b want 11", {writeDefault, plot}); end
    #2 reset = 1;
    #1 total++;
    if (allOut !== '0) begin bad++; $display("FAIL async_reset: got %h want 0", allOut); end
    repeat (2) @(negedge clock);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      total++;
      if ({plot, busy} !== 2'b00) begin bad++; $display("FAIL post_reset: plot/busy got %b want 00", {plot, busy}); end
    end
  endtask

  task automatic test_default_sweep();
    ev_t e;
    int cyc, wdCount, ldCount;
    logic [15:0] hA[3], hG[3], lastGrid, expG;
    q.delete();
    for (int i = 0; i < 43200; i++) push(3, 0, i);
    hA = '{default: '0};
    hG = '{default: '0};
    cyc = 0;
    wdCount = 0;
    ldCount = 0;
    lastGrid = '0;
    start = 1;
    while (q.size() > 0 && cyc < 45000) begin
      @(negedge clock);
      start = 0;
      cyc++;
      wdCount += int'(writeDefault);
      ldCount += int'(loadDefault);
      if (plot === 1'b1) begin
        e = q.pop_front();
        expG = {8'(e.j % 240), 8'(e.j / 240)};
        total++;
        if (hA[2] !== 16'(e.j)) begin bad++; $display("FAIL sweep_addr: issued %0d want %0d", hA[2], e.j); end
        total++;
        if (hG[1] !== expG) begin bad++; $display("FAIL sweep_grid: got %h want %h", hG[1], expG); end
        if (q.size() == 0) lastGrid = gridCounter;
      end
      hA[2] = hA[1]; hA[1] = hA[0]; hA[0] = memAddressGridCounter;
      hG[2] = hG[1]; hG[1] = hG[0]; hG[0] = gridCounter;
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL sweep_plots: missing %0d want 0", q.size()); end
    total++;
    if (lastGrid !== 16'hEFB3) begin bad++; $display("FAIL sweep_last_grid: got %h want efb3", lastGrid); end
    total++;
    if (wdCount != 43202) begin bad++; $display("FAIL write_default_len: got %0d want 43202", wdCount); end
    total++;
    if (ldCount != 43201) begin bad++; $display("FAIL load_default_len: got %0d want 43201", ldCount); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if ({plot, busy} !== 2'b01) begin bad++; $display("FAIL after_sweep: plot/busy got %b want 01", {plot, busy}); end
    end
  endtask

  task automatic test_beat();
    ev_t e;
    int cyc, k;
    logic prevW;
    logic [14:0] hA[3], hX[3], expX;
    q.delete();
    push(0, 0, 0);
    push(1, 0, 0);
    push(2, 0, 0);
    for (int b = 1; b <= 12; b++)
      for (int j = 0; j < 3600; j++) push(3, b, j);
    hA = '{default: '0};
    hX = '{default: '0};
    prevW = writeToScreen;
    cyc = 0;
    while (q.size() > 0 && cyc < 100000) begin
      @(negedge clock);
      cyc++;
      if (plot !== prevW) begin total++; bad++; $display("FAIL plot_lag: plot %b wts_prev %b", plot, prevW); end
      k = obsKind();
      if (k >= 0) begin
        e = q.pop_front();
        total++;
        if (k != e.kind) begin bad++; $display("FAIL beat_order: event %0d want %0d", k, e.kind); end
        else if (k == 3) begin
          expX = {8'(e.j / 60), 7'(e.j % 60)};
          total++;
          if (boxCounter !== 4'(e.box)) begin bad++; $display("FAIL box_order: got %0d want %0d", boxCounter, e.box); end
          total++;
          if (hA[2] !== 15'(e.j)) begin bad++; $display("FAIL box_addr: got %0d want %0d", hA[2], e.j); end
          total++;
          if (hX[2] !== expX) begin bad++; $display("FAIL box_pixel: got %h want %h", hX[2], expX); end
        end
      end
      prevW = writeToScreen;
      hA[2] = hA[1]; hA[1] = hA[0]; hA[0] = memAddressPixelCount;
      hX[2] = hX[1]; hX[1] = hX[0]; hX[0] = pixelCount;
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL beat_timeout: events left %0d want 0", q.size()); end
    @(negedge clock);
    total++;
    if ({boxCounter, busy, plot} !== 6'b000010) begin bad++; $display("FAIL after_redraw: box/busy/plot got %b want 000010", {boxCounter, busy, plot}); end
  endtask

  task automatic test_song_done();
    ev_t e;
    int cyc, k;
    start = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (writeDefault !== 1'b0) begin bad++; $display("FAIL start_while_busy: wd got %b want 0", writeDefault); end
    end
    q.delete();
    push(0, 0, 0);
    push(1, 0, 0);
    push(2, 0, 0);
    push(4, 0, 0);
    cyc = 0;
    while (q.size() > 0 && cyc < 50000) begin
      @(negedge clock);
      cyc++;
      k = obsKind();
      if (k >= 0) begin
        e = q.pop_front();
        total++;
        if (k != e.kind) begin bad++; $display("FAIL song_order: event %0d want %0d", k, e.kind); end
      end
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL song_timeout: events left %0d want 0", q.size()); end
    @(negedge clock);
    total++;
    if ({songDone, busy} !== 2'b00) begin bad++; $display("FAIL done_pulse: songDone/busy got %b want 00", {songDone, busy}); end
    @(negedge clock);
    total++;
    if ({writeDefault, busy} !== 2'b11) begin bad++; $display("FAIL restart: wd/busy got %b want 11", {writeDefault, busy}); end
    start = 0;
    #2 reset = 1;
    #1 total++;
    if ({plot, busy, writeDefault} !== 3'b000) begin bad++; $display("FAIL final_reset: got %b want 000", {plot, busy, writeDefault}); end
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_default_sweep();
    test_beat();
    test_song_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
